// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: display reads get fixed-latency priority access to a single-port RAM;
// writer pixels wait in a one-entry holding register and drain into free RAM slots.
module vga_fb_arbiter #(
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24,
  parameter int RD_LAT = 2
) (
  input  logic              clk_25m,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [11:0]       rd_xpos,
  input  logic [11:0]       rd_ypos,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [11:0] H_ACT_C = 12'(H_ACT);
  localparam logic [11:0] V_ACT_C = 12'(V_ACT);

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_RD   = 2'd1,
    GRANT_WR   = 2'd2
  } grant_e;

  logic              in_range_s;
  logic [23:0]       row_base_s;
  logic [23:0]       lin_addr_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              rd_go_s;

  logic              load_s;
  logic              hold_full_r;
  logic              hold_full_next_s;
  logic [ADDR_W-1:0] hold_addr_r;
  logic [ADDR_W-1:0] hold_addr_next_s;
  logic [DATA_W-1:0] hold_data_r;
  logic [DATA_W-1:0] hold_data_next_s;
  grant_e            grant_next_s;

  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              wr_done_r;
  logic              wr_ready_r;

  logic [RD_LAT:0]   vld_pipe_r;
  logic [RD_LAT:0]   rng_pipe_r;
  logic [DATA_W-1:0] rd_data_s;

  // Stage 0: range check and linear address of the requested pixel.
  always_comb begin
    in_range_s = (rd_xpos < H_ACT_C) && (rd_ypos < V_ACT_C);
    row_base_s = {12'd0, rd_ypos} * {12'd0, H_ACT_C};
    lin_addr_s = row_base_s + {12'd0, rd_xpos};
    rd_addr_s  = ADDR_W'(lin_addr_s);
    rd_go_s    = rd_req & in_range_s;
  end

  // Holding-register next state and slot arbitration for the following cycle.
  always_comb begin
    load_s           = wr_valid & wr_ready_r;
    hold_full_next_s = hold_full_r;
    hold_addr_next_s = hold_addr_r;
    hold_data_next_s = hold_data_r;
    grant_next_s     = GRANT_NONE;
    if (load_s) begin
      hold_full_next_s = 1'b1;
      hold_addr_next_s = wr_addr;
      hold_data_next_s = wr_data;
    end else if (wr_done_r) begin
      // The write granted this cycle empties the register at the edge.
      hold_full_next_s = 1'b0;
    end else begin
      hold_full_next_s = hold_full_r;
    end
    if (rd_go_s) begin
      grant_next_s = GRANT_RD;
    end else if (hold_full_next_s) begin
      grant_next_s = GRANT_WR;
    end else begin
      grant_next_s = GRANT_NONE;
    end
  end

  // Holding register and writer handshake.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_r <= 1'b0;
      hold_addr_r <= {ADDR_W{1'b0}};
      hold_data_r <= {DATA_W{1'b0}};
      wr_ready_r  <= 1'b1;
    end else begin
      hold_full_r <= hold_full_next_s;
      hold_addr_r <= hold_addr_next_s;
      hold_data_r <= hold_data_next_s;
      wr_ready_r  <= ~hold_full_next_s;
    end
  end

  // RAM port: address and data hold their last value when idle so they never go X.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      wr_done_r   <= 1'b0;
    end else begin
      case (grant_next_s)
        GRANT_RD: begin
          mem_en_r    <= 1'b1;
          mem_we_r    <= 1'b0;
          mem_addr_r  <= rd_addr_s;
          mem_wdata_r <= mem_wdata_r;
          wr_done_r   <= 1'b0;
        end
        GRANT_WR: begin
          mem_en_r    <= 1'b1;
          mem_we_r    <= 1'b1;
          mem_addr_r  <= hold_addr_next_s;
          mem_wdata_r <= hold_data_next_s;
          wr_done_r   <= 1'b1;
        end
        default: begin
          mem_en_r    <= 1'b0;
          mem_we_r    <= 1'b0;
          mem_addr_r  <= mem_addr_r;
          mem_wdata_r <= mem_wdata_r;
          wr_done_r   <= 1'b0;
        end
      endcase
    end
  end

  // Return pipeline: a request taken at t surfaces at t+1+RD_LAT regardless of writes.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_r <= {(RD_LAT+1){1'b0}};
      rng_pipe_r <= {(RD_LAT+1){1'b0}};
    end else begin
      vld_pipe_r <= {vld_pipe_r[RD_LAT-1:0], rd_req};
      rng_pipe_r <= {rng_pipe_r[RD_LAT-1:0], in_range_s};
    end
  end

  // RAM data arrives in the same cycle as the qualifier, so the final mux is combinational.
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    if (vld_pipe_r[RD_LAT] && rng_pipe_r[RD_LAT]) begin
      rd_data_s = mem_rdata;
    end else begin
      rd_data_s = {DATA_W{1'b0}};
    end
  end

  assign rd_data   = rd_data_s;
  assign rd_valid  = vld_pipe_r[RD_LAT];
  assign wr_ready  = wr_ready_r;
  assign wr_done   = wr_done_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port, pipelined frame-buffer RAM between the VGA display read path and a pixel writer (pattern generator or host loader).
- Sits between vga_driver (consumes vga_request/xpos/ypos, supplies vga_data) and the on-chip frame-buffer RAM.
- Display reads have absolute priority and fixed latency. Writes are buffered in a one-entry holding register and drain into idle RAM slots, mostly during blanking.

Parameters:
- H_ACT, 640, active pixels per line; read address = ypos*H_ACT + xpos
- V_ACT, 480, active lines
- ADDR_W, 19, RAM address width; must satisfy 2^ADDR_W >= H_ACT*V_ACT
- DATA_W, 24, pixel width, packed {r,g,b}
- RD_LAT, 2, RAM read latency in cycles from mem_en to mem_rdata; legal range 1..4

Ports:
- clk_25m  in  1  pixel clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  display pixel request (vga_request)
- rd_xpos  in  12  requested pixel column
- rd_ypos  in  12  requested pixel row
- rd_data  out  DATA_W  pixel returned to display
- rd_valid  out  1  rd_data qualifier
- wr_valid  in  1  writer has a pixel
- wr_ready  out  1  holding register empty; write accepted on wr_valid&wr_ready
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write pixel
- wr_done  out  1  one-cycle pulse when a buffered write commits to RAM
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable, valid with mem_en
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, RD_LAT cycles after a read strobe

Behaviour:
- Reset: all outputs 0 except wr_ready, which is 1. Holding register empty. Read pipeline flushed. In-flight reads are discarded and produce no rd_valid after reset release.
- Stage 0 (cycle t, rd_req=1): compute in_range = (xpos<H_ACT)&&(ypos<V_ACT) and addr = ypos*H_ACT+xpos, truncated to ADDR_W.
- Stage 1 (t+1), in-range read: mem_en=1, mem_we=0, mem_addr=registered addr.
- Out-of-range read: no RAM access at t+1; that slot is free for writes.
- Return: at t+1+RD_LAT, rd_valid=1 and rd_data = mem_rdata, or 0 if out of range. Latency is always RD_LAT+1, independent of write traffic.
- Arbitration at t+1 is evaluated every cycle:
  - GRANT_RD if a registered in-range read is present.
  - Else GRANT_WR if the holding register is full.
  - Else GRANT_NONE (mem_en=0).
  - mem_addr and mem_wdata are don't-care when mem_en=0, but must not toggle X in simulation; hold the last value.
- GRANT_WR: mem_en=1, mem_we=1, mem_addr/mem_wdata from the holding register. In the same cycle wr_done=1 and the holding register empties. wr_ready rises the following cycle.
- Holding register:
  - Loads on wr_valid&wr_ready; wr_ready drops the next cycle.
  - No load and drain in the same cycle: wr_ready is registered and is 0 while full. Peak write throughput is therefore 1 pixel per 2 cycles.
- Back-to-back reads (continuous rd_req across the active line): one read per cycle, no bubbles; writes stall for the whole line.
- Read/write address collision: a write grant never overlaps a read grant. A read issued before a write to the same address returns old data. A read issued after the write returns new data. No forwarding.
- rd_req deasserting mid-line creates free slots immediately, at the next t+1.
- Multiply width: 12x10 bit product into ADDR_W, computed combinationally in stage 0. The result is registered, so the timing path is single-cycle.

Test Plan:
1. Reset with rst_n=0 mid-stream, holding register full and 2 reads in flight -> all outputs 0, wr_ready=1 one cycle after release. No rd_valid for flushed reads. No mem_en until new traffic arrives.
2. RAM preloaded with addr value as data; single rd_req, x=5, y=2 -> mem_en/mem_addr=1285 at t+1; rd_valid with rd_data=1285 at t+3 (RD_LAT=2).
3. Continuous rd_req for 640 cycles while wr_valid is held high -> 640 consecutive reads, mem_we never 1, wr_done=0. After rd_req falls, first write commits at the next free slot with wr_done=1.
4. rd_req with x=700, y=10 -> no mem_en for that request. rd_valid at t+3 with rd_data=0. A pending write uses that slot.
5. wr_valid held high with no reads, addresses 0..7 -> accepts every 2nd cycle, 8 wr_done pulses, RAM contents match.
6. Write addr=100, data=0xABCDEF committed; then read of x=100, y=0 -> 0xABCDEF. A read issued one cycle before the write commits -> old value.
